decode_redirect: RTL and testbench

- Decode-side partner of the instruction fetch unit in the 5-stage MIPS pipeline (addu, subu, ori, lw, sw, beq, lui, j, jal, jr, nop).
- Consumes fetch-stage PC and instr and holds the F/D register.
- Resolves beq/j/jal/jr in D and drives the redirect and stall controls back to fetch.
- Keeps an internal 2-slot scoreboard of in-flight destinations (E, M) to decide D-stage stalls; branch delay slot architectural, so no flush on redirect.

---
 rtl/decode_redirect_pkg.sv | 50 +++++
 rtl/decode_redirect_instr_class.sv | 59 +++++
 rtl/decode_redirect.sv | 97 +++++++++
 tb/tb_decode_redirect.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_redirect_pkg.sv
// Shared definitions for the decode/redirect stage.
//   - MIPS opcode and funct constants for the supported subset
//   - sb_slot_t : one in-flight destination record (E or M stage)
//   - instr_class_t : decoded operand-usage summary of one instruction
//   - slot_hit() : does a scoreboard slot produce a given nonzero register
package decode_redirect_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;

  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_JR      = 6'h08;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_slot_t;

  localparam sb_slot_t SLOT_EMPTY = '{valid: 1'b0, dest: 5'd0, is_load: 1'b0};

  // reads_*_d : operand needed by the comparator/jr logic in D
  // reads_*_e : operand needed by the ALU/address adder in E
  typedef struct packed {
    logic [4:0] dest;
    logic       reads_rs_d;
    logic       reads_rt_d;
    logic       reads_rs_e;
    logic       reads_rt_e;
    logic       is_load;
    logic       is_beq;
    logic       is_j;
    logic       is_jr;
  } instr_class_t;

  // $0 is hardwired, so a dependency on it is never a hazard.
  function automatic logic slot_hit(input sb_slot_t slot, input logic [4:0] r,
                                    input logic need_load);
    return slot.valid && (slot.dest == r) && (r != 5'd0) &&
           (!need_load || slot.is_load);
  endfunction

endpackage

// File: rtl/decode_redirect_instr_class.sv
// Purely combinational instruction classifier.
//   instr : 32-bit instruction word
//   cls   : destination register and operand-usage flags
// Anything not in the supported subset classifies as a nop.
module instr_class
  import decode_redirect_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic [31:0]  instr,
  output instr_class_t cls
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned, which would otherwise infer a latch.
    cls = '0;
    case (instr[31:26])
      OP_SPECIAL: begin
        case (instr[5:0])
          FN_ADDU, FN_SUBU: begin
            cls.dest       = instr[15:11];
            cls.reads_rs_e = 1'b1;
            cls.reads_rt_e = 1'b1;
          end
          FN_JR: begin
            cls.reads_rs_d = 1'b1;
            cls.is_jr      = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        cls.dest       = instr[20:16];
        cls.reads_rs_e = 1'b1;
      end
      OP_LUI: cls.dest = instr[20:16];
      OP_LW: begin
        cls.dest       = instr[20:16];
        cls.reads_rs_e = 1'b1;
        cls.is_load    = 1'b1;
      end
      // sw's store data is forwarded at M, so only the base register counts.
      OP_SW:  cls.reads_rs_e = 1'b1;
      OP_BEQ: begin
        cls.reads_rs_d = 1'b1;
        cls.reads_rt_d = 1'b1;
        cls.is_beq     = 1'b1;
      end
      OP_J:   cls.is_j = 1'b1;
      OP_JAL: begin
        cls.is_j = 1'b1;
        cls.dest = LINK_REG;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_redirect.sv
// Decode stage of the 5-stage MIPS pipeline: F/D register, branch/jump
// resolution and stall generation from a 2-slot (E, M) destination scoreboard.
//   clk, reset (async, active-low)
//   F_PC, F_instr      : fetch-stage PC / instruction
//   rs_data, rt_data   : forwarded register operands for D_rs / D_rt
//   Stall_PC_F         : hold fetch PC
//   PCSrc/Jump/jr      : redirect enables (gated off while stalled)
//   PCBranch/PCJump/jrAddr : redirect targets (always driven)
//   D_PC, D_instr, D_rs, D_rt : F/D register contents and register fields
//   D_issue            : D_instr moves to E at the next edge
//   stall_cnt          : saturating count of stall cycles
// The branch delay slot is architectural: a redirect never flushes F.
module decode_redirect
  import decode_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00003000,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_PC,
  input  logic [31:0] F_instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        Stall_PC_F,
  output logic        PCSrc,
  output logic        Jump,
  output logic        jr,
  output logic [31:0] jrAddr,
  output logic [31:0] PCBranch,
  output logic [31:0] PCJump,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic [4:0]  D_rs,
  output logic [4:0]  D_rt,
  output logic        D_issue,
  output logic [31:0] stall_cnt
);

  sb_slot_t     slot_e, slot_m;
  instr_class_t cls;
  logic         stall;
  logic         hz_rs_d, hz_rt_d, hz_rs_e, hz_rt_e;

  instr_class #(.LINK_REG(LINK_REG)) u_class (
    .instr (D_instr),
    .cls   (cls)
  );

  assign D_rs = D_instr[25:21];
  assign D_rt = D_instr[20:16];

  // D-stage readers (beq/jr) wait for any producer in E and for a load in M;
  // E-stage readers only wait for a load in E (ALU results forward to E).
  assign hz_rs_d = cls.reads_rs_d &&
                   (slot_hit(slot_e, D_rs, 1'b0) || slot_hit(slot_m, D_rs, 1'b1));
  assign hz_rt_d = cls.reads_rt_d &&
                   (slot_hit(slot_e, D_rt, 1'b0) || slot_hit(slot_m, D_rt, 1'b1));
  assign hz_rs_e = cls.reads_rs_e && slot_hit(slot_e, D_rs, 1'b1);
  assign hz_rt_e = cls.reads_rt_e && slot_hit(slot_e, D_rt, 1'b1);

  assign stall      = hz_rs_d || hz_rt_d || hz_rs_e || hz_rt_e;
  assign Stall_PC_F = stall;
  assign D_issue    = !stall;

  assign PCBranch = D_PC + 32'd4 + {{14{D_instr[15]}}, D_instr[15:0], 2'b00};
  assign PCJump   = {D_PC[31:28], D_instr[25:0], 2'b00};
  assign jrAddr   = rs_data;

  // Operands may still be stale while stalled, so the enables wait.
  assign PCSrc = !stall && cls.is_beq && (rs_data == rt_data);
  assign Jump  = !stall && cls.is_j;
  assign jr    = !stall && cls.is_jr;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      D_PC      <= RESET_PC;
      D_instr   <= '0;
      slot_e    <= SLOT_EMPTY;
      slot_m    <= SLOT_EMPTY;
      stall_cnt <= '0;
    end else begin
      slot_m <= slot_e;
      if (stall) begin
        slot_e <= SLOT_EMPTY;
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      end else begin
        D_PC    <= F_PC;
        D_instr <= F_instr;
        slot_e  <= '{valid: 1'b1, dest: cls.dest, is_load: cls.is_load};
      end
    end
  end

endmodule

// File: tb/tb_decode_redirect.sv
// Directed bench for decode_redirect. A register-ready-time model predicts
// stalls: each issued producer marks the cycle from which its result is
// usable by D-stage readers (beq/jr) and by E-stage readers (ALU/address).
module tb_decode_redirect;

  logic        clk, reset;
  logic [31:0] F_PC, F_instr, rs_data, rt_data;
  logic        Stall_PC_F, PCSrc, Jump, jr, D_issue;
  logic [31:0] jrAddr, PCBranch, PCJump, D_PC, D_instr, stall_cnt;
  logic [4:0]  D_rs, D_rt;

  decode_redirect dut (
    .clk(clk), .reset(reset), .F_PC(F_PC), .F_instr(F_instr),
    .rs_data(rs_data), .rt_data(rt_data), .Stall_PC_F(Stall_PC_F),
    .PCSrc(PCSrc), .Jump(Jump), .jr(jr), .jrAddr(jrAddr),
    .PCBranch(PCBranch), .PCJump(PCJump), .D_PC(D_PC), .D_instr(D_instr),
    .D_rs(D_rs), .D_rt(D_rt), .D_issue(D_issue), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {K_NOP, K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_JAL, K_JR} kind_t;

  function automatic kind_t kind_of(input logic [31:0] i);
    case (i[31:26])
      6'h00: return (i[5:0] == 6'h21) ? K_ADDU :
                    (i[5:0] == 6'h23) ? K_SUBU :
                    (i[5:0] == 6'h08) ? K_JR : K_NOP;
      6'h0d: return K_ORI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04: return K_BEQ;
      6'h0f: return K_LUI;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] i);
    kind_t k;
    k = kind_of(i);
    if (k == K_ADDU || k == K_SUBU) return i[15:11];
    if (k == K_ORI || k == K_LUI || k == K_LW) return i[20:16];
    if (k == K_JAL) return 5'd31;
    return 5'd0;
  endfunction

  logic [31:0] m_pc, m_instr, m_cnt;
  int          m_cyc;
  int          rdy_d[32];
  int          rdy_e[32];

  function automatic logic m_stall();
    kind_t k;
    logic [4:0] s, t;
    logic d_rs, d_rt, e_rs, e_rt;
    k = kind_of(m_instr);
    s = m_instr[25:21];
    t = m_instr[20:16];
    d_rs = (k == K_BEQ) || (k == K_JR);
    d_rt = (k == K_BEQ);
    e_rs = (k == K_ADDU) || (k == K_SUBU) || (k == K_SW) || (k == K_ORI) || (k == K_LW);
    e_rt = (k == K_ADDU) || (k == K_SUBU);
    return (d_rs && s != 0 && m_cyc < rdy_d[s]) || (d_rt && t != 0 && m_cyc < rdy_d[t]) ||
           (e_rs && s != 0 && m_cyc < rdy_e[s]) || (e_rt && t != 0 && m_cyc < rdy_e[t]);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc    <= 32'h00003000;
      m_instr <= 32'h0;
      m_cnt   <= 32'h0;
      m_cyc   <= 0;
      for (int r = 0; r < 32; r++) begin
        rdy_d[r] <= 0;
        rdy_e[r] <= 0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_stall()) begin
        if (m_cnt != 32'hFFFFFFFF) m_cnt <= m_cnt + 1;
      end else begin
        m_pc    <= F_PC;
        m_instr <= F_instr;
        if (dest_of(m_instr) != 5'd0) begin
          // A load result reaches D readers one cycle later than an ALU result,
          // and E readers one cycle later as well.
          rdy_d[dest_of(m_instr)] <= m_cyc + ((kind_of(m_instr) == K_LW) ? 3 : 2);
          rdy_e[dest_of(m_instr)] <= m_cyc + ((kind_of(m_instr) == K_LW) ? 2 : 1);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("Stall_PC_F", {31'b0, Stall_PC_F}, {31'b0, m_stall()});
      check("D_issue", {31'b0, D_issue}, {31'b0, !m_stall()});
      check("D_PC", D_PC, m_pc);
      check("D_instr", D_instr, m_instr);
      check("D_rs", {27'b0, D_rs}, {27'b0, m_instr[25:21]});
      check("D_rt", {27'b0, D_rt}, {27'b0, m_instr[20:16]});
      check("stall_cnt", stall_cnt, m_cnt);
      check("PCBranch", PCBranch, m_pc + 32'd4 + 32'(4 * int'($signed(m_instr[15:0]))));
      check("PCJump", PCJump, {m_pc[31:28], 28'(m_instr[25:0] * 4)});
      check("jrAddr", jrAddr, rs_data);
      check("PCSrc", {31'b0, PCSrc},
            {31'b0, !m_stall() && kind_of(m_instr) == K_BEQ && rs_data == rt_data});
      check("Jump", {31'b0, Jump},
            {31'b0, !m_stall() && (kind_of(m_instr) == K_J || kind_of(m_instr) == K_JAL)});
      check("jr", {31'b0, jr}, {31'b0, !m_stall() && kind_of(m_instr) == K_JR});
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] rsd;
    logic [31:0] rtd;
  } row_t;

  row_t rows[1:22];

  initial begin
    // Row i is driven during cycle i; rs/rt data belong to the instruction in D.
    rows[1]  = '{32'h3004, 32'h8C020000, 32'h0, 32'h0};    // lw $2,0($0)
    rows[2]  = '{32'h3008, 32'h00421821, 32'h0, 32'h0};    // addu $3,$2,$2
    rows[3]  = '{32'h300C, 32'h8C040000, 32'h0, 32'h0};    // lw $4,0($0)
    rows[4]  = '{32'h300C, 32'h8C040000, 32'h0, 32'h0};
    rows[5]  = '{32'h3010, 32'h10800003, 32'h0, 32'h0};    // beq $4,$0,3
    rows[6]  = '{32'h3014, 32'h8C000000, 32'h0, 32'h0};    // lw $0,0($0)
    rows[7]  = '{32'h3014, 32'h8C000000, 32'h0, 32'h0};
    rows[8]  = '{32'h3014, 32'h8C000000, 32'h0, 32'h0};
    rows[9]  = '{32'h3018, 32'h00003821, 32'h0, 32'h0};    // addu $7,$0,$0
    rows[10] = '{32'h301C, 32'h8C080000, 32'h0, 32'h0};    // lw $8,0($0)
    rows[11] = '{32'h3020, 32'h01084821, 32'h0, 32'h0};    // addu $9,$8,$8
    rows[12] = '{32'h3024, 32'h00000000, 32'h0, 32'h0};
    rows[13] = '{32'h3000, 32'h10A6FFFF, 32'h0, 32'h0};    // beq $5,$6,-1
    rows[14] = '{32'h3004, 32'h00210021, 32'h1, 32'h2};    // addu $0,$1,$1
    rows[15] = '{32'h3008, 32'h10000001, 32'h0, 32'h0};    // beq $0,$0,1
    rows[16] = '{32'h300C, 32'h3C0A1234, 32'h0, 32'h0};    // lui $10,0x1234
    rows[17] = '{32'h3010, 32'h0C000C10, 32'h0, 32'h0};    // jal 0x000C10
    rows[18] = '{32'h3014, 32'h03E00008, 32'h0, 32'h0};    // jr $31
    rows[19] = '{32'h3018, 32'h00000000, 32'h3018, 32'h0};
    rows[20] = '{32'h3018, 32'h00000000, 32'h3018, 32'h0};
    rows[21] = '{32'h301C, 32'hFFFFFFFF, 32'h0, 32'h0};    // unrecognised
    rows[22] = '{32'h3020, 32'h00000000, 32'h5, 32'h5};

    reset   = 1'b0;
    F_PC    = 32'h3000;
    F_instr = 32'h34010005;                                 // ori $1,$0,5
    rs_data = 32'h0;
    rt_data = 32'h0;
    @(posedge clk);
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("lit_rst_D_PC", D_PC, 32'h3000);
    check("lit_rst_D_instr", D_instr, 32'h0);
    check("lit_rst_stall_cnt", stall_cnt, 32'h0);
    check("lit_rst_stall", {31'b0, Stall_PC_F}, 32'h0);
    reset = 1'b1;

    for (int i = 1; i <= 22; i++) begin
      @(posedge clk);
      #1;
      if (i == 13) reset = 1'b1;
      F_PC    = rows[i].pc;
      F_instr = rows[i].ins;
      rs_data = rows[i].rsd;
      rt_data = rows[i].rtd;
      #3;
      case (i)
        1: begin
          check("lit_c1_D_instr", D_instr, 32'h34010005);
          check("lit_c1_issue", {31'b0, D_issue}, 32'h1);
        end
        3: begin
          check("lit_c3_D_instr", D_instr, 32'h00421821);
          check("lit_c3_stall", {31'b0, Stall_PC_F}, 32'h1);
          check("lit_c3_issue", {31'b0, D_issue}, 32'h0);
        end
        4: begin
          check("lit_c4_cnt", stall_cnt, 32'h1);
          check("lit_c4_stall", {31'b0, Stall_PC_F}, 32'h0);
        end
        6, 7: begin
          check("lit_beq_wait_stall", {31'b0, Stall_PC_F}, 32'h1);
          check("lit_beq_wait_pcsrc", {31'b0, PCSrc}, 32'h0);
        end
        8: begin
          check("lit_c8_stall", {31'b0, Stall_PC_F}, 32'h0);
          check("lit_c8_pcsrc", {31'b0, PCSrc}, 32'h1);
          check("lit_c8_pcbranch", PCBranch, 32'h3020);
          check("lit_c8_cnt", stall_cnt, 32'h3);
        end
        10: check("lit_c10_r0_load", {31'b0, Stall_PC_F}, 32'h0);
        12: begin
          check("lit_c12_stall", {31'b0, Stall_PC_F}, 32'h1);
          reset = 1'b0;
          #1;
          check("lit_midrst_D_PC", D_PC, 32'h3000);
          check("lit_midrst_D_instr", D_instr, 32'h0);
          check("lit_midrst_stall", {31'b0, Stall_PC_F}, 32'h0);
        end
        13: begin
          check("lit_c13_D_PC", D_PC, 32'h3000);
          check("lit_c13_D_instr", D_instr, 32'h0);
          check("lit_c13_cnt", stall_cnt, 32'h0);
          check("lit_c13_stall", {31'b0, Stall_PC_F}, 32'h0);
        end
        14: begin
          check("lit_c14_pcsrc", {31'b0, PCSrc}, 32'h0);
          check("lit_c14_pcbranch", PCBranch, 32'h3000);
        end
        16: begin
          check("lit_c16_r0_alu", {31'b0, Stall_PC_F}, 32'h0);
          check("lit_c16_pcsrc", {31'b0, PCSrc}, 32'h1);
          check("lit_c16_pcbranch", PCBranch, 32'h3010);
        end
        18: begin
          check("lit_c18_jump", {31'b0, Jump}, 32'h1);
          check("lit_c18_pcjump", PCJump, 32'h3040);
        end
        19: begin
          check("lit_c19_stall", {31'b0, Stall_PC_F}, 32'h1);
          check("lit_c19_D_PC", D_PC, 32'h3014);
          check("lit_c19_jr", {31'b0, jr}, 32'h0);
        end
        20: begin
          check("lit_c20_jr", {31'b0, jr}, 32'h1);
          check("lit_c20_jraddr", jrAddr, 32'h3018);
          check("lit_c20_cnt", stall_cnt, 32'h1);
        end
        22: begin
          check("lit_c22_D_instr", D_instr, 32'hFFFFFFFF);
          check("lit_c22_redir", {29'b0, PCSrc, Jump, jr}, 32'h0);
          check("lit_c22_stall", {31'b0, Stall_PC_F}, 32'h0);
        end
        default: ;
      endcase
    end

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
